mt_ckpt: RTL and testbench
==========================

Name: mt_ckpt

Overview:
- Parametrised rename map table with branch checkpoints. It maps architectural registers to physical tags for a DISPATCH_W-wide dispatch group.
- It tracks per-entry ready bits, which CDB broadcasts set by physical-tag match.
- It holds NUM_CKPT in-order snapshots for single-cycle mispredict recovery.
- It sits between decode/free list and ROB/RS in the dispatch stage.

Parameters:
NUM_AR, 32, architectural registers
AR_W, 5, log2(NUM_AR)
PR_W, 7, physical tag width
DISPATCH_W, 2, instructions renamed per cycle
CDB_W, 4, CDB broadcast ports
NUM_CKPT, 4, checkpoint slots (power of 2)
CK_W, 2, log2(NUM_CKPT)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
disp_num  in  CK_W+1 (min enough for DISPATCH_W)  valid slots this cycle, slots 0..disp_num-1
disp_dest_valid  in  DISPATCH_W  slot writes a register
disp_dest_ar  in  DISPATCH_W*AR_W  dest arch reg per slot
disp_dest_pr  in  DISPATCH_W*PR_W  new tag from free list per slot
disp_src1_ar, disp_src2_ar  in  DISPATCH_W*AR_W  source arch regs
told  out  DISPATCH_W*PR_W  previous mapping of each slot's dest, to ROB
src1_pr, src2_pr  out  DISPATCH_W*PR_W  renamed sources, to RS
src1_ready, src2_ready  out  DISPATCH_W  source value available
cdb_valid  in  CDB_W  broadcast valid
cdb_pr  in  CDB_W*PR_W  broadcast tags
ckpt_req  in  1  take checkpoint this cycle
ckpt_slot  in  CK_W  snapshot taken after renaming slots 0..ckpt_slot
ckpt_id  out  CK_W  id assigned to current ckpt_req (= tail pointer)
ckpt_full  out  1  no free checkpoint
ckpt_release  in  1  oldest checkpoint's branch resolved correctly; free it
recover  in  1  mispredict; restore from recover_id
recover_id  in  CK_W  checkpoint to restore

Behaviour:
- Reset (async, reset low):
  - map[i]=i; all ready bits 1.
  - Checkpoint head=tail=0, count=0; ckpt_full=0.
  - All checkpoint contents 0.
- Lookup (combinational):
  - For slot j, src/told take the newest write by slots i<j (valid, dest_valid, same ar); otherwise map[ar].
  - A bypassed source has ready=0.
  - A non-bypassed source is ready if the stored ready bit is 1 OR the stored tag matches any valid cdb_pr this cycle.
- Update (clock edge):
  - For slots < disp_num with dest_valid: map[ar]<=dest_pr and ready[ar]<=0.
  - On a same-ar collision, the highest slot wins.
  - CDB: any entry whose current tag equals a valid cdb_pr gets ready<=1.
  - A dispatch write to the same entry in the same cycle takes priority over the CDB set.
- Checkpoint allocate:
  - When ckpt_req and not ckpt_full, snapshot slot[tail] <= map/ready state after renaming slots 0..ckpt_slot this cycle, including that cycle's CDB sets.
  - tail++ (wraps mod NUM_CKPT), count++.
  - ckpt_req while full is ignored; upstream must stall.
  - ckpt_req with ckpt_slot >= disp_num is allowed and snapshots the full-group result.
- Checkpoint snoop: every valid checkpoint's ready bits are set by CDB tag match on its own stored tags, every cycle.
- Release: ckpt_release with count>0 does head++, count--. Simultaneous release and allocate leaves count unchanged.
- Recovery:
  - recover has highest priority. Map/ready <= snapshot[recover_id], including that cycle's CDB match against the snapshot tags.
  - tail <= recover_id, count <= recover_id-head (mod NUM_CKPT). This frees recover_id and all younger checkpoints.
  - Dispatch, ckpt_req and ckpt_release are ignored that cycle.
  - recover with an invalid id (not in head..tail-1) is illegal; the bench does not drive it.
- Latency:
  - Rename outputs are 0-cycle.
  - State is visible to lookup the cycle after the update.
  - Restored map is visible the cycle after recover.
- ckpt_full = (count==NUM_CKPT), registered.
- Reset asserted mid-operation discards all checkpoints immediately.

Test Plan:
- Post-reset, src1_ar=5 -> src1_pr=5, ready=1; ckpt_full=0.
- Dispatch 2: slot0 r3->p40, slot1 src1=r3, dest r3->p41 -> slot1 src1_pr=40 ready=0, told1=40, told0=3; next cycle map[3]=41, ready[3]=0.
- Entry r3=p41 not ready; cdb_valid[2]=1, cdb_pr=41 while r3 is read -> src ready=1 same cycle; next cycle stored ready=1.
- ckpt_req slot0 with r7->p50, slot1 r7->p51; then r7->p52; recover to that id -> map[7]=50. If p50 was broadcast in between, ready[7]=1.
- Allocate 4 checkpoints -> ckpt_full=1, 5th request ignored. Release one plus allocate same cycle -> ckpt_full stays 1. Recover id=head+1 -> count=1.
- Reset low asynchronously mid-recover -> map identity and count=0 without a clock edge.

Source files
------------

// File: rtl/mt_ckpt.sv
// mt_ckpt: rename map table with in-order branch checkpoints.
//
// Maps architectural registers to physical tags for a DISPATCH_W-wide
// dispatch group, tracks a ready bit per entry (set by CDB tag match),
// and keeps NUM_CKPT snapshots for single-cycle mispredict recovery.
//
// Ports
//   clock_i, reset_ni          clock, async active-low reset
//   disp_*_i                   dispatch group (slots 0..disp_num_i-1 valid)
//   told_o                     previous mapping of each slot's dest
//   src1/2_pr_o, src1/2_ready_o renamed sources and their availability
//   cdb_valid_i, cdb_pr_i      result broadcasts
//   ckpt_req_i, ckpt_slot_i    take snapshot after renaming slots 0..ckpt_slot_i
//   ckpt_id_o, ckpt_full_o     id for the current request, no free slot
//   ckpt_release_i             free the oldest checkpoint
//   recover_i, recover_id_i    restore from a checkpoint, drop it and younger
module mt_ckpt #(
   parameter int NUM_AR     = 32,
   parameter int AR_W       = 5,
   parameter int PR_W       = 7,
   parameter int DISPATCH_W = 2,
   parameter int CDB_W      = 4,
   parameter int NUM_CKPT   = 4,
   parameter int CK_W       = 2
) (
   input  logic                       clock_i,
   input  logic                       reset_ni,
   input  logic [CK_W:0]              disp_num_i,
   input  logic [DISPATCH_W-1:0]      disp_dest_valid_i,
   input  logic [DISPATCH_W*AR_W-1:0] disp_dest_ar_i,
   input  logic [DISPATCH_W*PR_W-1:0] disp_dest_pr_i,
   input  logic [DISPATCH_W*AR_W-1:0] disp_src1_ar_i,
   input  logic [DISPATCH_W*AR_W-1:0] disp_src2_ar_i,
   output logic [DISPATCH_W*PR_W-1:0] told_o,
   output logic [DISPATCH_W*PR_W-1:0] src1_pr_o,
   output logic [DISPATCH_W*PR_W-1:0] src2_pr_o,
   output logic [DISPATCH_W-1:0]      src1_ready_o,
   output logic [DISPATCH_W-1:0]      src2_ready_o,
   input  logic [CDB_W-1:0]           cdb_valid_i,
   input  logic [CDB_W*PR_W-1:0]      cdb_pr_i,
   input  logic                       ckpt_req_i,
   input  logic [CK_W-1:0]            ckpt_slot_i,
   output logic [CK_W-1:0]            ckpt_id_o,
   output logic                       ckpt_full_o,
   input  logic                       ckpt_release_i,
   input  logic                       recover_i,
   input  logic [CK_W-1:0]            recover_id_i
);
   localparam int CNT_W = CK_W + 1;

   logic [PR_W-1:0]   map_q    [NUM_AR];
   logic [PR_W-1:0]   map_d    [NUM_AR];
   logic [PR_W-1:0]   snap_map [NUM_AR];
   logic [NUM_AR-1:0] rdy_q, rdy_d, snap_rdy;

   logic [PR_W-1:0]   ck_map_q [NUM_CKPT][NUM_AR];
   logic [NUM_AR-1:0] ck_rdy_q [NUM_CKPT];
   logic [NUM_AR-1:0] ck_rdy_d [NUM_CKPT];

   logic [CK_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q;
   logic              alloc, rel;

   function automatic logic cdb_hit(input logic [PR_W-1:0]       tag,
                                    input logic [CDB_W-1:0]      v,
                                    input logic [CDB_W*PR_W-1:0] prs);
      logic h;
      h = 1'b0;
      for (int c = 0; c < CDB_W; c++) h = h | (v[c] && (prs[c*PR_W +: PR_W] == tag));
      return h;
   endfunction

   // Rename lookup with intra-group bypass: a later slot sees the newest
   // earlier write to the same arch reg, and such a value is never ready yet.
   always_comb begin
      logic [AR_W-1:0] d_ar, s1_ar, s2_ar, w_ar;
      logic [PR_W-1:0] t_pr, p1, p2, w_pr;
      logic            r1, r2;
      told_o       = '0;
      src1_pr_o    = '0;
      src2_pr_o    = '0;
      src1_ready_o = '0;
      src2_ready_o = '0;
      for (int j = 0; j < DISPATCH_W; j++) begin
         d_ar  = disp_dest_ar_i[j*AR_W +: AR_W];
         s1_ar = disp_src1_ar_i[j*AR_W +: AR_W];
         s2_ar = disp_src2_ar_i[j*AR_W +: AR_W];
         t_pr  = map_q[d_ar];
         p1    = map_q[s1_ar];
         p2    = map_q[s2_ar];
         r1    = rdy_q[s1_ar] | cdb_hit(p1, cdb_valid_i, cdb_pr_i);
         r2    = rdy_q[s2_ar] | cdb_hit(p2, cdb_valid_i, cdb_pr_i);
         for (int i = 0; i < j; i++) begin
            w_ar = disp_dest_ar_i[i*AR_W +: AR_W];
            w_pr = disp_dest_pr_i[i*PR_W +: PR_W];
            if (i < int'(disp_num_i) && disp_dest_valid_i[i]) begin
               if (w_ar == d_ar) t_pr = w_pr;
               if (w_ar == s1_ar) begin
                  p1 = w_pr;
                  r1 = 1'b0;
               end
               if (w_ar == s2_ar) begin
                  p2 = w_pr;
                  r2 = 1'b0;
               end
            end
         end
         told_o[j*PR_W +: PR_W]    = t_pr;
         src1_pr_o[j*PR_W +: PR_W] = p1;
         src2_pr_o[j*PR_W +: PR_W] = p2;
         src1_ready_o[j]           = r1;
         src2_ready_o[j]           = r2;
      end
   end

   // Live checkpoints keep snooping the CDB against their own stored tags.
   always_comb begin
      for (int k = 0; k < NUM_CKPT; k++) begin
         ck_rdy_d[k] = ck_rdy_q[k];
         if ({1'b0, CK_W'(k) - head_q} < count_q) begin
            for (int a = 0; a < NUM_AR; a++) begin
               if (cdb_hit(ck_map_q[k][a], cdb_valid_i, cdb_pr_i)) ck_rdy_d[k][a] = 1'b1;
            end
         end
      end
   end

   // Next map state. CDB sets land first so a same-cycle dispatch write wins;
   // the snapshot stops after slot ckpt_slot_i.
   always_comb begin
      logic [AR_W-1:0] w_ar;
      logic [PR_W-1:0] w_pr;
      for (int a = 0; a < NUM_AR; a++) begin
         map_d[a] = map_q[a];
         rdy_d[a] = rdy_q[a] | cdb_hit(map_q[a], cdb_valid_i, cdb_pr_i);
      end
      snap_map = map_d;
      snap_rdy = rdy_d;
      for (int i = 0; i < DISPATCH_W; i++) begin
         w_ar = disp_dest_ar_i[i*AR_W +: AR_W];
         w_pr = disp_dest_pr_i[i*PR_W +: PR_W];
         if (i < int'(disp_num_i) && disp_dest_valid_i[i]) begin
            map_d[w_ar] = w_pr;
            rdy_d[w_ar] = 1'b0;
            if (i <= int'(ckpt_slot_i)) begin
               snap_map[w_ar] = w_pr;
               snap_rdy[w_ar] = 1'b0;
            end
         end
      end
      if (recover_i) begin
         for (int a = 0; a < NUM_AR; a++) map_d[a] = ck_map_q[recover_id_i][a];
         rdy_d = ck_rdy_d[recover_id_i];
      end
   end

   // A release in the same cycle frees the head slot, which is exactly the
   // tail slot when full, so a request is accepted then as well.
   always_comb begin
      rel     = ckpt_release_i && (count_q != '0) && !recover_i;
      alloc   = ckpt_req_i && (!full_q || rel) && !recover_i;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (recover_i) begin
         tail_d  = recover_id_i;
         count_d = {1'b0, recover_id_i - head_q};
      end else begin
         if (rel)   head_d = head_q + CK_W'(1);
         if (alloc) tail_d = tail_q + CK_W'(1);
         if (alloc && !rel)      count_d = count_q + CNT_W'(1);
         else if (rel && !alloc) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int a = 0; a < NUM_AR; a++) map_q[a] <= PR_W'(a);
         rdy_q <= '1;
         for (int k = 0; k < NUM_CKPT; k++) begin
            ck_rdy_q[k] <= '0;
            for (int a = 0; a < NUM_AR; a++) ck_map_q[k][a] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         map_q <= map_d;
         rdy_q <= rdy_d;
         for (int k = 0; k < NUM_CKPT; k++) ck_rdy_q[k] <= ck_rdy_d[k];
         if (alloc) begin
            ck_map_q[tail_q] <= snap_map;
            ck_rdy_q[tail_q] <= snap_rdy;
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(NUM_CKPT));
      end
   end

   assign ckpt_id_o   = tail_q;
   assign ckpt_full_o = full_q;
endmodule

// File: tb/tb_mt_ckpt.sv
module tb_mt_ckpt;
   localparam int NUM_AR = 32;
   localparam int AR_W   = 5;
   localparam int PR_W   = 7;
   localparam int DW     = 2;
   localparam int CDB_W  = 4;
   localparam int NCK    = 4;
   localparam int CK_W   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [CK_W:0]     disp_num;
   logic [DW-1:0]     dv;
   logic [AR_W-1:0]   dar [DW];
   logic [AR_W-1:0]   s1a [DW];
   logic [AR_W-1:0]   s2a [DW];
   logic [PR_W-1:0]   dpr [DW];
   logic [CDB_W-1:0]  cdb_v;
   logic [PR_W-1:0]   cdb_t [CDB_W];
   logic              ckpt_req, ckpt_rel, recover;
   logic [CK_W-1:0]   ckpt_slot, recover_id;

   logic [DW*AR_W-1:0]    dar_bus, s1_bus, s2_bus;
   logic [DW*PR_W-1:0]    dpr_bus;
   logic [CDB_W*PR_W-1:0] cdb_bus;
   logic [DW*PR_W-1:0]    told_bus, p1_bus, p2_bus;
   logic [DW-1:0]         r1_bus, r2_bus;
   logic [CK_W-1:0]       ckpt_id;
   logic                  ckpt_full;

   always_comb begin
      for (int j = 0; j < DW; j++) begin
         dar_bus[j*AR_W +: AR_W] = dar[j];
         s1_bus[j*AR_W +: AR_W]  = s1a[j];
         s2_bus[j*AR_W +: AR_W]  = s2a[j];
         dpr_bus[j*PR_W +: PR_W] = dpr[j];
      end
      for (int c = 0; c < CDB_W; c++) cdb_bus[c*PR_W +: PR_W] = cdb_t[c];
   end

   mt_ckpt dut (
      .clock_i(clk), .reset_ni(rst_n),
      .disp_num_i(disp_num), .disp_dest_valid_i(dv),
      .disp_dest_ar_i(dar_bus), .disp_dest_pr_i(dpr_bus),
      .disp_src1_ar_i(s1_bus), .disp_src2_ar_i(s2_bus),
      .told_o(told_bus), .src1_pr_o(p1_bus), .src2_pr_o(p2_bus),
      .src1_ready_o(r1_bus), .src2_ready_o(r2_bus),
      .cdb_valid_i(cdb_v), .cdb_pr_i(cdb_bus),
      .ckpt_req_i(ckpt_req), .ckpt_slot_i(ckpt_slot),
      .ckpt_id_o(ckpt_id), .ckpt_full_o(ckpt_full),
      .ckpt_release_i(ckpt_rel), .recover_i(recover), .recover_id_i(recover_id)
   );

   initial forever #5 clk = ~clk;

   // Reference model: plain arrays for the table, a queue of live checkpoint
   // ids (oldest first) for the checkpoint ring.
   int m_map [NUM_AR];
   bit m_rdy [NUM_AR];
   int c_map [NCK][NUM_AR];
   bit c_rdy [NCK][NUM_AR];
   int live [$];
   int m_tail;
   bit m_full;

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hit(int tag);
      for (int c = 0; c < CDB_W; c++)
         if (cdb_v[c] && int'(cdb_t[c]) == tag) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < NUM_AR; a++) begin
         m_map[a] = a;
         m_rdy[a] = 1'b1;
         for (int k = 0; k < NCK; k++) begin
            c_map[k][a] = 0;
            c_rdy[k][a] = 1'b0;
         end
      end
      live.delete();
      m_tail = 0;
      m_full = 1'b0;
   endtask

   task automatic idle();
      disp_num = '0; dv = '0; cdb_v = '0;
      ckpt_req = 1'b0; ckpt_rel = 1'b0; recover = 1'b0;
      ckpt_slot = '0; recover_id = '0;
      for (int j = 0; j < DW; j++) begin
         dar[j] = '0; s1a[j] = '0; s2a[j] = '0; dpr[j] = '0;
      end
      for (int c = 0; c < CDB_W; c++) cdb_t[c] = '0;
   endtask

   task automatic check_outputs();
      for (int j = 0; j < DW; j++) begin
         int t, p1, p2;
         bit q1, q2;
         t  = m_map[dar[j]];
         p1 = m_map[s1a[j]];
         p2 = m_map[s2a[j]];
         q1 = m_rdy[s1a[j]] || hit(p1);
         q2 = m_rdy[s2a[j]] || hit(p2);
         for (int i = 0; i < j; i++) begin
            if (i < int'(disp_num) && dv[i]) begin
               if (dar[i] == dar[j]) t = int'(dpr[i]);
               if (dar[i] == s1a[j]) begin p1 = int'(dpr[i]); q1 = 1'b0; end
               if (dar[i] == s2a[j]) begin p2 = int'(dpr[i]); q2 = 1'b0; end
            end
         end
         chk($sformatf("told[%0d]", j), int'(told_bus[j*PR_W +: PR_W]), t);
         chk($sformatf("src1_pr[%0d]", j), int'(p1_bus[j*PR_W +: PR_W]), p1);
         chk($sformatf("src2_pr[%0d]", j), int'(p2_bus[j*PR_W +: PR_W]), p2);
         chk($sformatf("src1_ready[%0d]", j), int'(r1_bus[j]), int'(q1));
         chk($sformatf("src2_ready[%0d]", j), int'(r2_bus[j]), int'(q2));
      end
      chk("ckpt_id", int'(ckpt_id), m_tail);
      chk("ckpt_full", int'(ckpt_full), int'(m_full));
   endtask

   task automatic commit();
      int n_map [NUM_AR];
      bit n_rdy [NUM_AR];
      int s_map [NUM_AR];
      bit s_rdy [NUM_AR];
      bit rel, alloc;
      for (int k = 0; k < live.size(); k++)
         for (int a = 0; a < NUM_AR; a++)
            if (hit(c_map[live[k]][a])) c_rdy[live[k]][a] = 1'b1;
      if (recover) begin
         int rid;
         rid = int'(recover_id);
         for (int a = 0; a < NUM_AR; a++) begin
            m_map[a] = c_map[rid][a];
            m_rdy[a] = c_rdy[rid][a];
         end
         while (live.size() > 0) begin
            int x;
            x = live.pop_back();
            if (x == rid) break;
         end
         m_tail = rid;
      end else begin
         for (int a = 0; a < NUM_AR; a++) begin
            n_map[a] = m_map[a];
            n_rdy[a] = m_rdy[a] || hit(m_map[a]);
            s_map[a] = n_map[a];
            s_rdy[a] = n_rdy[a];
         end
         for (int i = 0; i < DW; i++) begin
            if (i < int'(disp_num) && dv[i]) begin
               n_map[dar[i]] = int'(dpr[i]);
               n_rdy[dar[i]] = 1'b0;
               if (i <= int'(ckpt_slot)) begin
                  s_map[dar[i]] = int'(dpr[i]);
                  s_rdy[dar[i]] = 1'b0;
               end
            end
         end
         for (int a = 0; a < NUM_AR; a++) begin
            m_map[a] = n_map[a];
            m_rdy[a] = n_rdy[a];
         end
         rel   = ckpt_rel && live.size() > 0;
         alloc = ckpt_req && (live.size() < NCK || rel);
         if (rel) void'(live.pop_front());
         if (alloc) begin
            for (int a = 0; a < NUM_AR; a++) begin
               c_map[m_tail][a] = s_map[a];
               c_rdy[m_tail][a] = s_rdy[a];
            end
            live.push_back(m_tail);
            m_tail = (m_tail + 1) % NCK;
         end
      end
      m_full = (live.size() == NCK);
   endtask

   // One cycle: check the settled outputs against the model, then advance
   // the model on the same edge the DUT updates.
   task automatic step();
      #1;
      check_outputs();
      @(posedge clk);
      commit();
      #1;
   endtask

   initial begin
      idle();
      model_reset();
      #12 rst_n = 1'b1;

      // post-reset identity map
      s1a[0] = 5'd5;
      #1;
      chk("reset src1_pr", int'(p1_bus[0 +: PR_W]), 5);
      chk("reset src1_ready", int'(r1_bus[0]), 1);
      chk("reset ckpt_full", int'(ckpt_full), 0);
      step();

      // intra-group bypass on r3
      idle();
      disp_num = 3'd2;
      dv = 2'b11;
      dar[0] = 5'd3; dpr[0] = 7'd40;
      dar[1] = 5'd3; dpr[1] = 7'd41; s1a[1] = 5'd3;
      #1;
      chk("bypass src1_pr", int'(p1_bus[PR_W +: PR_W]), 40);
      chk("bypass src1_ready", int'(r1_bus[1]), 0);
      chk("bypass told1", int'(told_bus[PR_W +: PR_W]), 40);
      chk("bypass told0", int'(told_bus[0 +: PR_W]), 3);
      step();
      idle();
      s1a[0] = 5'd3;
      #1;
      chk("r3 map", int'(p1_bus[0 +: PR_W]), 41);
      chk("r3 not ready", int'(r1_bus[0]), 0);
      step();

      // same-cycle CDB wakeup then stored ready
      idle();
      s1a[0] = 5'd3;
      cdb_v[2] = 1'b1; cdb_t[2] = 7'd41;
      #1;
      chk("cdb same-cycle ready", int'(r1_bus[0]), 1);
      step();
      idle();
      s1a[0] = 5'd3;
      #1;
      chk("cdb stored ready", int'(r1_bus[0]), 1);
      step();

      // checkpoint after slot0, later overwrite, broadcast, recover
      idle();
      disp_num = 3'd2; dv = 2'b11;
      dar[0] = 5'd7; dpr[0] = 7'd50;
      dar[1] = 5'd7; dpr[1] = 7'd51;
      ckpt_req = 1'b1; ckpt_slot = 2'd0;
      #1;
      chk("ckpt id0", int'(ckpt_id), 0);
      step();
      idle();
      disp_num = 3'd1; dv = 2'b01;
      dar[0] = 5'd7; dpr[0] = 7'd52;
      cdb_v[0] = 1'b1; cdb_t[0] = 7'd50;
      step();
      idle();
      recover = 1'b1; recover_id = 2'd0;
      step();
      idle();
      s1a[0] = 5'd7;
      #1;
      chk("recover r7 map", int'(p1_bus[0 +: PR_W]), 50);
      chk("recover r7 ready", int'(r1_bus[0]), 1);
      step();

      // fill the ring
      for (int k = 0; k < NCK; k++) begin
         idle();
         ckpt_req = 1'b1;
         #1;
         chk("fill id", int'(ckpt_id), k);
         step();
      end
      idle();
      ckpt_req = 1'b1;
      #1;
      chk("full after 4", int'(ckpt_full), 1);
      step();
      idle();
      #1;
      chk("5th ignored id", int'(ckpt_id), 0);
      ckpt_req = 1'b1; ckpt_rel = 1'b1;
      step();
      idle();
      #1;
      chk("rel+alloc full", int'(ckpt_full), 1);
      chk("rel+alloc id", int'(ckpt_id), 1);
      recover = 1'b1; recover_id = 2'd2;
      step();
      idle();
      #1;
      chk("recover head+1 id", int'(ckpt_id), 2);
      chk("recover head+1 full", int'(ckpt_full), 0);
      for (int k = 0; k < 3; k++) begin
         idle();
         ckpt_req = 1'b1;
         step();
         if (k == 1) chk("count 3 not full", int'(ckpt_full), 0);
      end
      idle();
      #1;
      chk("count back to 4", int'(ckpt_full), 1);
      step();

      // async reset in the middle of a recover cycle
      idle();
      disp_num = 3'd1; dv = 2'b01;
      dar[0] = 5'd9; dpr[0] = 7'd77;
      step();
      idle();
      recover = 1'b1; recover_id = 2'(live[0]);
      s1a[0] = 5'd9;
      #1;
      chk("pre-reset r9", int'(p1_bus[0 +: PR_W]), 77);
      rst_n = 1'b0;
      #1;
      chk("async reset r9", int'(p1_bus[0 +: PR_W]), 9);
      chk("async reset ready", int'(r1_bus[0]), 1);
      chk("async reset full", int'(ckpt_full), 0);
      chk("async reset id", int'(ckpt_id), 0);
      model_reset();
      @(negedge clk);
      idle();
      @(posedge clk);
      #2 rst_n = 1'b1;

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         idle();
         disp_num = 3'($urandom_range(0, 2));
         for (int j = 0; j < DW; j++) begin
            dv[j]  = 1'($urandom_range(0, 1));
            dar[j] = $urandom_range(0, 1) ? AR_W'($urandom_range(0, 7)) : AR_W'($urandom_range(0, 31));
            s1a[j] = $urandom_range(0, 1) ? AR_W'($urandom_range(0, 7)) : AR_W'($urandom_range(0, 31));
            s2a[j] = $urandom_range(0, 1) ? AR_W'($urandom_range(0, 7)) : AR_W'($urandom_range(0, 31));
            dpr[j] = PR_W'($urandom_range(0, 127));
         end
         for (int c = 0; c < CDB_W; c++) begin
            cdb_v[c] = 1'($urandom_range(0, 1));
            cdb_t[c] = $urandom_range(0, 1) ? PR_W'(m_map[$urandom_range(0, 31)]) : PR_W'($urandom_range(0, 127));
         end
         ckpt_req  = ($urandom_range(0, 9) < 3);
         ckpt_slot = CK_W'($urandom_range(0, 3));
         ckpt_rel  = ($urandom_range(0, 9) < 2);
         if (live.size() > 0 && $urandom_range(0, 19) == 0) begin
            recover    = 1'b1;
            recover_id = CK_W'(live[$urandom_range(0, live.size() - 1)]);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
